sync_count_lock: RTL

Parametrised sync-to-counter stage for the video pipeline. It registers incoming HSync/VSync and drives free-running column/row counters that realign to the active VSync edge. It adds configurable sync polarity, widths and frame geometry, plus a frame-lock state machine that reports whether the incoming frame length matches the configured geometry. It sits between the timing generator and the pixel/pattern stages, so downstream blocks can gate output on a stable lock.

---
 rtl/sync_count_pkg.sv | 17 +
 rtl/sync_lock_fsm.sv | 76 +++++++
 rtl/sync_count_lock.sv | 102 ++++++++++
 3 files changed

// File: rtl/sync_count_pkg.sv
// Shared lock-state encoding and default 640x480 frame geometry for the sync counter stage.
package sync_count_pkg;

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        CHECK  = 2'd1,
        LOCKED = 2'd2
    } lock_state_t;

    localparam int DEF_TOTAL_COLS  = 800;
    localparam int DEF_TOTAL_ROWS  = 525;
    localparam int DEF_ACTIVE_COLS = 640;
    localparam int DEF_ACTIVE_ROWS = 480;
    localparam int DEF_COL_W       = 10;
    localparam int DEF_ROW_W       = 10;

endpackage

// File: rtl/sync_lock_fsm.sv
// Frame-lock tracker: grades each frame start and declares lock after LOCK_FRAMES good frames.
// Outputs registered, updated on the same edge as the counter reload; no backpressure.
module sync_lock_fsm
    import sync_count_pkg::*;
#(
    parameter int LOCK_FRAMES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic frame_start,
    input  logic good,
    input  logic missed,
    output logic o_Locked,
    output logic o_Frame_Err
);

    localparam int CNT_W = $clog2(LOCK_FRAMES + 1);

    lock_state_t      state;
    logic [CNT_W-1:0] good_cnt;
    logic [CNT_W-1:0] cnt_inc;

    // Saturating so a long run of good frames never wraps the count.
    assign cnt_inc = (good_cnt == CNT_W'(LOCK_FRAMES)) ? good_cnt : good_cnt + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= SEARCH;
            good_cnt    <= '0;
            o_Locked    <= 1'b0;
            o_Frame_Err <= 1'b0;
        end else begin
            o_Frame_Err <= 1'b0;
            case (state)
                SEARCH: begin
                    if (frame_start) begin
                        state    <= CHECK;
                        good_cnt <= '0;
                    end
                end
                CHECK: begin
                    if (frame_start && good) begin
                        good_cnt <= cnt_inc;
                        if (cnt_inc == CNT_W'(LOCK_FRAMES)) begin
                            state    <= LOCKED;
                            o_Locked <= 1'b1;
                        end
                    end else if (frame_start) begin
                        good_cnt    <= '0;
                        o_Frame_Err <= 1'b1;
                    end else if (missed) begin
                        state       <= SEARCH;
                        o_Frame_Err <= 1'b1;
                    end
                end
                LOCKED: begin
                    if (frame_start && !good) begin
                        state       <= CHECK;
                        good_cnt    <= '0;
                        o_Frame_Err <= 1'b1;
                        o_Locked    <= 1'b0;
                    end else if (missed) begin
                        state       <= SEARCH;
                        o_Frame_Err <= 1'b1;
                        o_Locked    <= 1'b0;
                    end
                end
                default: begin
                    state    <= SEARCH;
                    o_Locked <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/sync_count_lock.sv
// Registers HSync/VSync, runs col/row counters realigned on the VSync edge, reports frame lock.
// Latency 1 clock, no backpressure; SYNC_COUNT_ACTIVE_EN adds a registered o_Active_Video.
module sync_count_lock
    import sync_count_pkg::*;
#(
    parameter int TOTAL_COLS       = DEF_TOTAL_COLS,
    parameter int TOTAL_ROWS       = DEF_TOTAL_ROWS,
    parameter int ACTIVE_COLS      = DEF_ACTIVE_COLS,
    parameter int ACTIVE_ROWS      = DEF_ACTIVE_ROWS,
    parameter int COL_W            = DEF_COL_W,
    parameter int ROW_W            = DEF_ROW_W,
    parameter int SYNC_ACTIVE_HIGH = 1,
    parameter int LOCK_FRAMES      = 2
) (
    input  logic             i_Clk,
    input  logic             i_Rst,
    input  logic             i_HSync,
    input  logic             i_VSync,
    output logic             o_HSync,
    output logic             o_VSync,
    output logic [COL_W-1:0] o_Col_Count,
    output logic [ROW_W-1:0] o_Row_Count,
    output logic             o_Frame_Start,
    output logic             o_Frame_Err,
    output logic             o_Locked
`ifdef SYNC_COUNT_ACTIVE_EN
    ,
    output logic             o_Active_Video
`endif
);

    logic             v_act_in;
    logic             v_act_reg;
    logic             frame_start;
    logic             col_last;
    logic             row_last;
    logic             wrap;
    logic [COL_W-1:0] col_nxt;
    logic [ROW_W-1:0] row_nxt;

    assign v_act_in    = (SYNC_ACTIVE_HIGH != 0) ? i_VSync : ~i_VSync;
    assign v_act_reg   = (SYNC_ACTIVE_HIGH != 0) ? o_VSync : ~o_VSync;
    assign frame_start = v_act_in & ~v_act_reg;
    assign col_last    = (o_Col_Count == COL_W'(TOTAL_COLS - 1));
    assign row_last    = (o_Row_Count == ROW_W'(TOTAL_ROWS - 1));
    assign wrap        = col_last & row_last;

    always_comb begin
        col_nxt = o_Col_Count + 1'b1;
        row_nxt = o_Row_Count;
        if (frame_start) begin
            col_nxt = '0;
            row_nxt = '0;
        end else if (col_last) begin
            col_nxt = '0;
            row_nxt = row_last ? '0 : o_Row_Count + 1'b1;
        end
    end

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            o_HSync       <= 1'b0;
            o_VSync       <= 1'b0;
            o_Col_Count   <= '0;
            o_Row_Count   <= '0;
            o_Frame_Start <= 1'b0;
        end else begin
            o_HSync       <= i_HSync;
            o_VSync       <= i_VSync;
            o_Col_Count   <= col_nxt;
            o_Row_Count   <= row_nxt;
            o_Frame_Start <= frame_start;
        end
    end

`ifdef SYNC_COUNT_ACTIVE_EN
    // Based on next-state counts so the flag lines up with the registered counters.
    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            o_Active_Video <= 1'b0;
        end else begin
            o_Active_Video <= (int'(col_nxt) < ACTIVE_COLS) && (int'(row_nxt) < ACTIVE_ROWS);
        end
    end
`else
    logic unused_active_geom;
    assign unused_active_geom = ^{ACTIVE_COLS, ACTIVE_ROWS};
`endif

    sync_lock_fsm #(
        .LOCK_FRAMES (LOCK_FRAMES)
    ) u_lock_fsm (
        .clk         (i_Clk),
        .rst         (i_Rst),
        .frame_start (frame_start),
        .good        (frame_start & wrap),
        .missed      (wrap & ~frame_start),
        .o_Locked    (o_Locked),
        .o_Frame_Err (o_Frame_Err)
    );

endmodule
